// File: rtl/sync_fifo_core.sv
// ---------------------------------------------------------------------------
// sync_fifo_core
//
// Single-clock FIFO with a registered read-data output and registered
// full/empty flags. Writes that would overflow and reads that would underflow
// are blocked and leave the FIFO untouched.
//
// Parameters
//   DATA_WIDTH : bits per stored word
//   DEPTH      : number of entries (power of two, >= 2)
//
// Ports
//   clk       : clock, everything samples on the rising edge
//   rst       : synchronous active-high reset
//   wr_en     : write request, data_in pushed when accepted
//   rd_en     : read request, head word moved to data_out when accepted
//   data_in   : write data
//   data_out  : registered read data, holds when no read is accepted
//   full      : FIFO holds DEPTH words
//   empty     : FIFO holds no words
//
// Optional build macro SYNC_FIFO_ERR_EN adds:
//   overflow  : one-cycle pulse after a write was rejected because full
//   underflow : one-cycle pulse after a read was rejected because empty
// ---------------------------------------------------------------------------
module sync_fifo_core #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
`ifdef SYNC_FIFO_ERR_EN
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
`else
    output logic                  empty
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  wr_acc, rd_acc;

    // A write is still accepted while full if a read frees the head slot in
    // the same cycle. A read is never accepted while empty, so a concurrent
    // write into an empty FIFO is not passed straight through to data_out.
    always_comb begin
        wr_acc = wr_en & (~full_q | rd_en);
        rd_acc = rd_en & ~empty_q;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            data_out_d = mem_q[rd_ptr_q];
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        // Flags follow the post-edge occupancy so they update together with
        // the pointers.
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
        end
    end

    // Storage is deliberately not cleared on reset; the pointers make any
    // stale contents unreachable. A write in the reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out = data_out_q;
    assign full     = full_q;
    assign empty    = empty_q;

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Rejection conditions are the complements of the accept rules above.
    always_comb begin
        overflow_d  = wr_en & full_q & ~rd_en;
        underflow_d = rd_en & empty_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_core.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_core
//
// Directed scenarios followed by a randomized phase. Every cycle the outputs
// are compared with a queue-based reference model of the FIFO.
// ---------------------------------------------------------------------------
module tb_sync_fifo_core;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
`ifdef SYNC_FIFO_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    logic [DW-1:0] mq [$];
    logic [DW-1:0] m_dout;
    logic          m_ovf;
    logic          m_unf;
    int            ovf_pulses;
    int            unf_pulses;

    sync_fifo_core #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
`ifdef SYNC_FIFO_ERR_EN
        .empty    (empty),
        .overflow (overflow),
        .underflow(underflow)
`else
        .empty    (empty)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, advance the model at
    // the rising edge, compare all outputs 1 time unit later.
    task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
        bit mfull, mempty;
        @(negedge clk);
        rst = r; wr_en = w; rd_en = rd; data_in = d;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            mfull  = (mq.size() == DEPTH);
            mempty = (mq.size() == 0);
            m_ovf  = w && mfull && !rd;
            m_unf  = rd && mempty;
            if (rd && !mempty) m_dout = mq.pop_front();
            if (w && (!mfull || rd)) mq.push_back(d);
        end
        #1;
        check("data_out", 32'(data_out), 32'(m_dout));
        check("full",     32'(full),     32'(mq.size() == DEPTH));
        check("empty",    32'(empty),    32'(mq.size() == 0));
`ifdef SYNC_FIFO_ERR_EN
        check("overflow",  32'(overflow),  32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
        if (overflow === 1'b1)  ovf_pulses++;
        if (underflow === 1'b1) unf_pulses++;
`endif
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
        ovf_pulses = 0; unf_pulses = 0;

        // reset
        step(1, 0, 0, 8'h00);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full",  32'(full),  32'd0);
        check("reset_dout",  32'(data_out), 32'd0);

        // fill with 0..16, 17th word dropped
        for (int i = 0; i < 17; i++) begin
            step(0, 1, 0, 8'(i));
            if (i == 14) check("full_before_16th", 32'(full), 32'd0);
            if (i == 15) check("full_after_16th",  32'(full), 32'd1);
        end
        check("count_after_overflow", 32'(mq.size()), 32'd16);
`ifdef SYNC_FIFO_ERR_EN
        check("overflow_pulses", 32'(ovf_pulses), 32'd1);
`endif

        // drain 17 times: 0..15, then holds 15
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 1, 8'h00);
            if (i < 16) check("drain_order", 32'(data_out), 32'(i));
        end
        check("drain_hold_15", 32'(data_out), 32'd15);
        check("drain_empty",   32'(empty),    32'd1);
`ifdef SYNC_FIFO_ERR_EN
        check("underflow_pulses", 32'(unf_pulses), 32'd1);
`endif

        // concurrent read/write from empty
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 8'(100 + i));
            if (i == 0) check("concurrent_no_passthru", 32'(data_out), 32'd15);
            else        check("concurrent_dout", 32'(data_out), 32'(100 + i - 1));
            check("concurrent_empty", 32'(empty), 32'd0);
        end
        step(0, 0, 1, 8'h00);
        check("concurrent_last", 32'(data_out), 32'd107);
        step(0, 0, 1, 8'h00);
        check("concurrent_hold", 32'(data_out), 32'd107);

        // wrap-around
        for (int i = 0; i < 12; i++) step(0, 1, 0, 8'(i));
        for (int i = 0; i < 12; i++) step(0, 0, 1, 8'h00);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(8'hA0 + i));
        check("wrap_full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 8'h00);
            check("wrap_order", 32'(data_out), 32'(8'hA0 + i));
            check("wrap_not_full", 32'(full), 32'd0);
        end

        // write+read while full
        for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(i));
        step(0, 1, 1, 8'h55);
        check("wr_rd_full_dout", 32'(data_out), 32'd0);
        check("wr_rd_full_full", 32'(full), 32'd1);
        for (int i = 1; i < 17; i++) begin
            step(0, 0, 1, 8'h00);
            check("wr_rd_full_drain", 32'(data_out), (i < 16) ? 32'(i) : 32'h55);
        end

        // reset mid-operation with a pending write
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h30 + i));
        step(1, 1, 0, 8'h77);
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_dout",  32'(data_out), 32'd0);
        step(0, 1, 0, 8'h88);
        step(0, 0, 1, 8'h00);
        check("midrst_first", 32'(data_out), 32'h88);
        check("midrst_empty_after", 32'(empty), 32'd1);

        // randomized traffic with shifting bias so both full and empty are hit
        for (int p = 0; p < 4; p++) begin
            int wbias = (p % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 150; i++) begin
                step(($urandom_range(0, 199) == 0),
                     ($urandom_range(0, 99) < wbias),
                     ($urandom_range(0, 99) < (100 - wbias)),
                     8'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_core.md
Name: sync_fifo_core

Overview:
Single-clock, first-in first-out data buffer with a parameterised width and depth. It has a registered read-data output and `full`/`empty` status flags. Writes that would overflow and reads that would underflow are blocked and do not corrupt the FIFO. It is a generic buffering element between a producer and a consumer in the same clock domain.

Parameters:
- DATA_WIDTH, 8: bit width of each data word.
- DEPTH, 16: number of storage entries. Must be a power of two and at least 2. Address width AW = $clog2(DEPTH).

Ports:
- clk  input  1  system clock; all logic samples on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- wr_en  input  1  write request; data_in is pushed at the clock edge if accepted.
- rd_en  input  1  read request; the head word is popped to data_out at the clock edge if accepted.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- full  output  1  high when the FIFO holds DEPTH words.
- empty  output  1  high when the FIFO holds 0 words.

Behaviour:
- State:
  - Storage array of DEPTH x DATA_WIDTH.
  - wr_ptr and rd_ptr, each AW bits, wrapping modulo DEPTH.
  - Occupancy counter `count`, AW+1 bits, range 0..DEPTH.
- Reset (rst=1 at a rising edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - data_out=0, empty=1, full=0.
  - Storage contents are not cleared.
  - Reset takes priority over wr_en/rd_en in the same cycle. Reset mid-operation discards all stored data.
- Accept rules, evaluated on pre-edge state:
  - wr_acc = wr_en & (!full | rd_en).
  - rd_acc = rd_en & !empty.
- Write (wr_acc): mem[wr_ptr] <= data_in; wr_ptr increments with wrap.
- Read (rd_acc): data_out <= mem[rd_ptr]; rd_ptr increments with wrap.
  - Read latency is 1 cycle: data_out is valid after the edge at which rd_en was sampled.
- data_out holds its last value whenever rd_acc=0, including reads attempted while empty.
- Count update:
  - +1 on write-only.
  - -1 on read-only.
  - Unchanged on simultaneous write+read or when idle.
- Flags:
  - full = (count==DEPTH); empty = (count==0).
  - Both are registered or derived combinationally from `count`, so they reflect the post-edge occupancy in the same cycle as the pointer update.
- Boundary cases:
  - Write while full, no read: word dropped; pointers, count and contents unchanged.
  - Write+read while full: both performed; the head word is output, the new word is stored, and full stays 1.
  - Read while empty: ignored; data_out is unchanged.
  - Write+read while empty: write performed, read ignored. Count becomes 1 and empty deasserts. The word is not passed through to data_out in the same cycle.
  - Pointer wrap: after DEPTH accepted writes, wr_ptr returns to 0. Ordering is preserved across wrap.
- No X propagation on data_out after reset; outputs are defined in every cycle.

Optional Feature:
- Macro: SYNC_FIFO_ERR_EN.
- When defined, two extra outputs are added:
  - overflow (1 bit): registered, pulses high for one cycle after wr_en=1 is rejected because the FIFO is full.
  - underflow (1 bit): registered, pulses high for one cycle after rd_en=1 is rejected because the FIFO is empty.
  - Both reset to 0.
- When undefined, these ports and their logic are absent and the remaining behaviour is identical.

Test Plan:
- Reset check: hold rst=1 for 1 cycle, then release -> empty=1, full=0, data_out=0.
- Fill and overflow: with rd_en=0, wr_en=1, data_in=0,1,...,16 over 17 cycles.
  - full rises after the 16th write.
  - The 17th word (16) is dropped; count stays 16.
  - With ERR_EN defined, overflow pulses once.
- Drain and underflow: with wr_en=0, rd_en=1 for 17 cycles.
  - data_out = 0,1,...,15 in order; empty rises after the 16th read.
  - On the 17th read data_out holds 15.
  - With ERR_EN defined, underflow pulses once.
- Concurrent read/write from empty: wr_en=rd_en=1, data_in=100..107 for 8 cycles.
  - Cycle 1: read ignored; empty drops.
  - Cycles 2-8: data_out = 100..106; count stays 1, full=0.
  - Then wr_en=0, rd_en=1: data_out=107, empty=1, and data_out holds 107 thereafter.
- Wrap-around: write 12 words, read 12, then write 16 (values 0xA0..0xAF) and read 16.
  - Output is 0xA0..0xAF in order.
  - full=1 exactly between the final write and the first read.
- Write+read while full: with the FIFO full of 0..15, set wr_en=rd_en=1, data_in=0x55.
  - data_out=0 and full stays 1.
  - A subsequent drain yields 1..15, then 0x55.
- Reset mid-operation: with 5 words stored, assert rst for one cycle while wr_en=1 -> empty=1, count=0, the write is discarded, and the next written word is read first.
